// File: rtl/apc_stream_accumulator_if.sv
// Handshake and result bus between the SC lane block and the stream accumulator.
// The slave modport is the accumulator. The master modport is whoever drives beats and takes results.
interface apc_stream_accumulator_if #(
  parameter int APC_WIDTH = 4,
  parameter int ACC_WIDTH = 12
);
  logic                        start;
  logic                        in_valid;
  logic [APC_WIDTH-1:0]        apc_sum;
  logic                        busy;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_WIDTH-1:0]        result;
  logic signed [ACC_WIDTH:0]   bipolar;
  logic                        range_err;

  modport master (
    output start, in_valid, apc_sum, out_ready,
    input  busy, out_valid, result, bipolar, range_err
  );

  modport slave (
    input  start, in_valid, apc_sum, out_ready,
    output busy, out_valid, result, bipolar, range_err
  );
endinterface

// File: rtl/apc_stream_accumulator.sv
// Sums the per-cycle APC_8 ones-count over STREAM_LEN valid beats.
// Presents the unipolar total and the bipolar value 2*total - 8*STREAM_LEN.
//
// state  | meaning
// S_IDLE | waiting for start; in_valid ignored
// S_ACC  | accumulating beats; busy=1
// S_HOLD | result presented; out_valid=1 until out_ready
module apc_stream_accumulator #(
  parameter int APC_WIDTH  = 4,
  parameter int STREAM_LEN = 256,
  parameter int ACC_WIDTH  = 12
) (
  input logic                    clk,
  input logic                    rst,
  apc_stream_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(STREAM_LEN);
  localparam logic [APC_WIDTH-1:0] LANES      = APC_WIDTH'(8);
  localparam logic [CNT_W-1:0]     LAST_BEAT  = CNT_W'(STREAM_LEN - 1);
  localparam logic [ACC_WIDTH:0]   FULL_SCALE = (ACC_WIDTH + 1)'(8 * STREAM_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic [ACC_WIDTH:0]   bipolar_q, bipolar_d;
  logic                 range_err_q, range_err_d;

  logic                 over_range;
  logic [APC_WIDTH-1:0] beat;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 take_beat;
  logic                 last_beat;
  logic                 clear;

  assign over_range = bus.apc_sum > LANES;
  assign beat       = over_range ? LANES : bus.apc_sum;
  assign acc_sum    = acc_q + ACC_WIDTH'(beat);
  assign take_beat  = (state_q == S_ACC) && bus.in_valid;
  assign last_beat  = take_beat && (cnt_q == LAST_BEAT);
  // A start is honoured from IDLE, or back-to-back with the accepting handshake in HOLD.
  assign clear      = bus.start &&
                      ((state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_ACC;
      S_ACC:  if (last_beat) state_d = S_HOLD;
      S_HOLD: if (bus.out_ready) state_d = bus.start ? S_ACC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q == S_ACC);
    bus.out_valid = (state_q == S_HOLD);
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    bipolar_d   = bipolar_q;
    range_err_d = range_err_q;
    if (clear) begin
      acc_d       = '0;
      cnt_d       = '0;
      range_err_d = 1'b0;
    end else if (take_beat) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + 1'b1;
      if (over_range) range_err_d = 1'b1;
      if (last_beat) begin
        result_d  = acc_sum;
        // Modular at ACC_WIDTH+1 bits; the true value always fits the signed range.
        bipolar_d = {acc_sum, 1'b0} - FULL_SCALE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      bipolar_q   <= '0;
      range_err_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      bipolar_q   <= bipolar_d;
      range_err_q <= range_err_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.bipolar   = bipolar_q;
  assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_apc_stream_accumulator.sv
// Directed bench for apc_stream_accumulator with STREAM_LEN=256, ACC_WIDTH=12.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_apc_stream_accumulator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  apc_stream_accumulator_if #(.APC_WIDTH(4), .ACC_WIDTH(12)) bus ();

  apc_stream_accumulator #(
    .APC_WIDTH (4),
    .STREAM_LEN(256),
    .ACC_WIDTH (12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("busy_after_start", int'(bus.busy), 1);
  endtask

  // 256 beats of v; beat bad_idx carries bad_val; start is pulsed alongside beat start_idx.
  task automatic feed(input int v, input bit gap, input int bad_idx, input int bad_val,
                      input int start_idx);
    for (int i = 0; i < 256; i++) begin
      bus.in_valid = 1'b1;
      bus.apc_sum  = (i == bad_idx) ? 4'(bad_val) : 4'(v);
      bus.start    = (i == start_idx);
      if (i == 255) check_eq("ov_before_last", int'(bus.out_valid), 0);
      tick();
      bus.in_valid = 1'b0;
      bus.apc_sum  = '0;
      bus.start    = 1'b0;
      if (gap && i != 255) tick();
    end
    check_eq("ov_after_last", int'(bus.out_valid), 1);
  endtask

  task automatic check_result(input string tag, input int exp_res, input int exp_bip,
                              input int exp_err);
    check_eq({tag, "_result"}, int'(bus.result), exp_res);
    check_eq({tag, "_bipolar"}, int'($signed(bus.bipolar)), exp_bip);
    check_eq({tag, "_range_err"}, int'(bus.range_err), exp_err);
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("ov_after_accept", int'(bus.out_valid), 0);
    check_eq("busy_after_accept", int'(bus.busy), 0);
  endtask

  initial begin
    clk           = 1'b0;
    rst           = 1'b1;
    n_checks      = 0;
    n_errors      = 0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.apc_sum   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_result("rst", 0, 0, 0);
    rst = 1'b0;
    tick();

    // all-ones stream
    start_conv();
    feed(8, 1'b0, -1, 0, -1);
    check_result("t1", 2048, 2048, 0);
    accept();

    // all-zero and half-density streams
    start_conv();
    feed(0, 1'b0, -1, 0, -1);
    check_result("t2_zero", 0, -2048, 0);
    accept();
    start_conv();
    feed(4, 1'b0, -1, 0, -1);
    check_result("t2_half", 1024, 0, 0);
    accept();

    // in_valid gapped every other cycle
    start_conv();
    feed(3, 1'b1, -1, 0, -1);
    check_result("t3", 768, -512, 0);
    accept();

    // backpressure in HOLD, then accept with start for a back-to-back conversion
    start_conv();
    feed(2, 1'b0, -1, 0, -1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.apc_sum  = 4'd8;
      tick();
      check_eq("t4_hold_ov", int'(bus.out_valid), 1);
      check_eq("t4_hold_result", int'(bus.result), 512);
    end
    check_eq("t4_hold_bipolar", int'($signed(bus.bipolar)), -1024);
    bus.in_valid  = 1'b0;
    bus.apc_sum   = '0;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check_eq("t4_b2b_busy", int'(bus.busy), 1);
    check_eq("t4_b2b_ov", int'(bus.out_valid), 0);
    feed(1, 1'b0, -1, 0, -1);
    check_result("t4_ones", 256, -1536, 0);
    accept();

    // out-of-range beat is clamped and flagged until the next start
    start_conv();
    feed(0, 1'b0, 37, 12, -1);
    check_result("t5", 8, -2032, 1);
    accept();
    check_eq("t5_err_idle", int'(bus.range_err), 1);
    start_conv();
    check_eq("t5_err_cleared", int'(bus.range_err), 0);

    // reset at beat 100 discards the conversion already underway
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.apc_sum  = 4'd5;
      tick();
    end
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.apc_sum  = '0;
    check_eq("t6_rst_busy", int'(bus.busy), 0);
    check_eq("t6_rst_ov", int'(bus.out_valid), 0);
    check_result("t6_rst", 0, 0, 0);

    // start during ACC is ignored
    start_conv();
    feed(2, 1'b0, -1, 0, 50);
    check_result("t6_start_in_acc", 512, -1024, 0);
    accept();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
